// File: rtl/aes_output_buffer_visc.sv
// Output FIFO after the last AES stage: first-word fall-through, drops on full, sticky overflow.
// Optional AES_OBUF_DROP_CNT_EN adds a saturating drop_count output cleared by clr_overflow.
module aes_output_buffer_visc #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 128
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       can_accept,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  input  logic                       clr_overflow
`ifdef AES_OBUF_DROP_CNT_EN
  ,
  output logic [15:0]                drop_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             overflow_q, overflow_d;
  logic             push, pop, drop;

  assign out_valid  = (level_q != '0);
  assign can_accept = (level_q < LW'(DEPTH));
  assign level      = level_q;
  assign overflow   = overflow_q;
  // Zero while empty so the output is defined out of reset.
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;

  assign pop  = out_valid && out_ready;
  assign push = in_valid && (can_accept || pop);
  assign drop = in_valid && !push;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
    if (drop)              overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is intentionally not reset; out_valid masks stale entries.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

`ifdef AES_OBUF_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clr_overflow)                     drop_cnt_d = drop ? 16'd1 : 16'd0;
    else if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule
